// File: rtl/adder_seq_arb.sv
// Nibble-serial add sequencer with round-robin arbitration of a 4-bit adder slice.
// Optional signed overflow flag: define ADDSEQ_OVF_DETECT_EN.
module adder_seq_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic             ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;
  logic             last;
  logic             gnt_any;
  logic             gnt_id;

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIB - 1));

  // ptr high means requester 1 wins a tie
  always_comb begin
    gnt_any = req0 | req1;
    gnt_id  = req1 & (~req0 | ptr);
  end

  // Slice operands only leave the block while a nibble is in flight
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = op_a[base +: 4];
      add_b   = op_b[base +: 4];
      add_cin = carry;
    end
  end

  // Arbitration, nibble sequencing and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      owner  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            owner <= gnt_id;
            ptr   <= ~gnt_id;
            op_a  <= gnt_id ? a1 : a0;
            op_b  <= gnt_id ? b1 : b0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result[base +: 4] <= add_sum;
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            cout  <= add_cout;
            done  <= 1'b1;
            ack0  <= ~owner;
            ack1  <= owner;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDSEQ_OVF_DETECT_EN
  // Two's-complement overflow, captured with the final carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
             (add_sum[3] != op_a[WIDTH-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/adder_seq_arb.md
Name: adder_seq_arb

Overview:
Nibble-serial sequencer and two-port arbiter for the shared 4-bit adder slice. It accepts WIDTH-bit add requests from two requesters and grants the slice round-robin. It feeds the operands through the slice one nibble per cycle, least-significant nibble first, chaining the carry in a register. It returns the full WIDTH-bit sum, the carry-out and a one-cycle acknowledge to the winning requester.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NIB, WIDTH/4, derived nibble count (localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 add request; held until ack0
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
ack0  output  1  one-cycle completion pulse to requester 0
req1  input  1  requester 1 add request; held until ack1
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
ack1  output  1  one-cycle completion pulse to requester 1
add_a  output  4  nibble A to adder slice
add_b  output  4  nibble B to adder slice
add_cin  output  1  carry-in to adder slice
add_sum  input  4  slice sum, combinational, valid in the same cycle
add_cout  input  1  slice carry-out, same cycle
busy  output  1  high from grant through DONE
done  output  1  one-cycle pulse, result/cout valid
owner  output  1  id of the last-granted requester
result  output  WIDTH  registered sum
cout  output  1  registered final carry-out
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n. Reset clears busy, done, ack0, ack1, owner, result, cout, ovf, the carry register and the nibble index to 0. State returns to IDLE. The round-robin pointer is reset to favour requester 0.
- Reset mid-operation: the operation is aborted, no ack is issued, and no result is updated.
- add_a, add_b and add_cin are combinational. They are 0 outside RUN.
- IDLE: sample req0 and req1 at the clock edge.
  - Exactly one request: grant it.
  - Both requests: grant the one favoured by the pointer, then flip the pointer to favour the other requester.
  - A single grant also sets the pointer to favour the non-granted requester.
  - On grant: latch the winner's a/b into internal operand registers, set owner, clear carry and index, set busy, go to RUN.
- RUN, index i = 0..NIB-1:
  - Drive add_a = A[4i+3:4i], add_b = B[4i+3:4i], add_cin = carry.
  - At the edge: result[4i+3:4i] <= add_sum, carry <= add_cout, i <= i+1.
  - At i = NIB-1: cout <= add_cout, go to DONE.
- DONE (one cycle): done = 1, ack[owner] = 1, busy = 1. Next state is IDLE; busy drops on that edge.
- Latency: a request sampled at edge k produces done/ack high in the cycle after edge k+NIB (NIB = 4 gives 5 cycles). Back-to-back throughput is one operation per NIB+2 cycles.
- Request handling:
  - Operands are captured at grant. Changes to a/b or deassertion of req during RUN are ignored, and the operation completes normally.
  - A requester must drop req on the edge that ends its ack cycle. A req still high in IDLE starts a new operation.
- result, cout and ovf hold their values until the next operation's DONE. Partial nibbles are written during RUN, so result is only valid when done = 1 or afterwards.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.

Optional Feature:
- Macro: ADDSEQ_OVF_DETECT_EN.
- Defined: at the last RUN edge, ovf <= (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[3] != A[WIDTH-1]). This is the two's-complement overflow flag, registered alongside cout.
- Undefined: ovf is tied to 0 and no extra logic is generated.

Test Plan:
- Single add: WIDTH=16; req0, a0=0x1234, b0=0x0FCD -> busy set; done and ack0 high 5 cycles after grant edge; result=0x2201, cout=0, ack1 never high.
- Full carry ripple: a0=0xFFFF, b0=0x0001 -> result=0x0000, cout=1; add_cin=1 on nibbles 1-3.
- Contention: req0 and req1 both held from reset with distinct operands -> grant order 0,1,0; each ack pulses exactly once per operation; owner tracks the grants.
- Request drop: req1 with 0x00F0+0x0010, req1 deasserted at nibble 1 -> operation completes, result=0x0100, ack1 pulses.
- Reset mid-RUN: rst_n low during nibble 2 -> all outputs 0 immediately, no ack. After release, a fresh req0 with 0x0003+0x0004 returns result=0x0007.
- Overflow (macro defined): 0x7FFF+0x0001 -> result=0x8000, cout=0, ovf=1. With the macro undefined, ovf=0.
